// File: rtl/aes_pkg.sv
// Shared AES-128 decryption types, round constants and GF(2^8) arithmetic helpers.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        ADDK   = 2'd2,
        ROUND  = 2'd3
    } aes_fsm_e;

    localparam int NR = 10;
    localparam logic [7:0] RCON_FIRST = 8'h01;
    localparam logic [7:0] RCON_LAST  = 8'h36;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns
// unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] roundKey_i,
    input  logic         isLast_i,
    output logic [127:0] state_o
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [31:0] invMixColumn(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;
    logic [127:0] mixed;

    // Byte k sits at row k%4, column k/4; row r is rotated right by r columns.
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127 - 8*(4*c + r) -: 8] = state_i[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
    end

    always_comb begin
        subbed = '0;
        for (int k = 0; k < 16; k++) begin
            subbed[127 - 8*k -: 8] = INV_SBOX[shifted[127 - 8*k -: 8]];
        end
    end

    assign keyed = subbed ^ roundKey_i;

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32*c -: 32] = invMixColumn(keyed[127 - 32*c -: 32]);
        end
    end

    assign state_o = isLast_i ? keyed : mixed;

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryptor: 10-cycle forward key expansion, K10 whitening, then one inverse
// round per cycle while the key walks backward. Define AES_DEC_KEYCACHE_EN to reuse a cached K10.
module aes_decrypt_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] cipher_in,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         valid_out,
    output logic [127:0] plain_out
);

    localparam logic [3:0] LAST_ROUND = 4'(NR - 1);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // SubWord(RotWord(w)) with w = {a0,a1,a2,a3} and a0 in the top byte.
    function automatic logic [31:0] subRotWord(input logic [31:0] w);
        return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
    endfunction

    function automatic logic [127:0] keyStepFwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ subRotWord(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Undo one expansion step; rc is the constant that produced k from its predecessor.
    function automatic logic [127:0] keyStepBwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0]  ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ subRotWord(p3) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    aes_fsm_e     fsm_q;
    logic [127:0] cipherState_q;
    logic [127:0] roundKey_q;
    logic [127:0] plainOut_q;
    logic [7:0]   rcon_q;
    logic [3:0]   roundCnt_q;
    logic         busy_q;
    logic         validOut_q;

    logic [127:0] keyFwd_d;
    logic [127:0] keyBwd_d;
    logic [127:0] roundState_d;
    logic [7:0]   rconPrev_d;
    logic         cacheHit;
    logic [127:0] cachedK10;

    assign keyFwd_d   = keyStepFwd(roundKey_q, rcon_q);
    assign keyBwd_d   = keyStepBwd(roundKey_q, rcon_q);
    assign rconPrev_d = {1'b0, rcon_q[7:1]} ^ (rcon_q[0] ? 8'h8d : 8'h00);

    aes_inv_round uInvRound (
        .state_i    (cipherState_q),
        .roundKey_i (keyBwd_d),
        .isLast_i   (roundCnt_q == 4'd0),
        .state_o    (roundState_d)
    );

`ifdef AES_DEC_KEYCACHE_EN
    logic [127:0] cacheKey_q;
    logic [127:0] cacheK10_q;
    logic         cacheValid_q;

    assign cacheHit  = cacheValid_q && (key_in == cacheKey_q);
    assign cachedK10 = cacheK10_q;

    // A miss claims the cache for the new key; it becomes valid once its K10 is known.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cacheKey_q   <= '0;
            cacheK10_q   <= '0;
            cacheValid_q <= 1'b0;
        end else if (fsm_q == IDLE && start) begin
            if (!cacheHit) begin
                cacheKey_q   <= key_in;
                cacheValid_q <= 1'b0;
            end
        end else if (fsm_q == EXPAND && roundCnt_q == LAST_ROUND) begin
            cacheK10_q   <= keyFwd_d;
            cacheValid_q <= 1'b1;
        end
    end
`else
    assign cacheHit  = 1'b0;
    assign cachedK10 = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q         <= IDLE;
            cipherState_q <= '0;
            roundKey_q    <= '0;
            plainOut_q    <= '0;
            rcon_q        <= '0;
            roundCnt_q    <= '0;
            busy_q        <= 1'b0;
            validOut_q    <= 1'b0;
        end else begin
            validOut_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        cipherState_q <= cipher_in;
                        roundCnt_q    <= '0;
                        rcon_q        <= RCON_FIRST;
                        busy_q        <= 1'b1;
                        if (cacheHit) begin
                            roundKey_q <= cachedK10;
                            fsm_q      <= ADDK;
                        end else begin
                            roundKey_q <= key_in;
                            fsm_q      <= EXPAND;
                        end
                    end
                end
                EXPAND: begin
                    roundKey_q <= keyFwd_d;
                    rcon_q     <= xtime(rcon_q);
                    roundCnt_q <= roundCnt_q + 4'd1;
                    if (roundCnt_q == LAST_ROUND) fsm_q <= ADDK;
                end
                // Both the expansion and cache-hit paths arrive here with K10 in the key register.
                ADDK: begin
                    cipherState_q <= cipherState_q ^ roundKey_q;
                    rcon_q        <= RCON_LAST;
                    roundCnt_q    <= LAST_ROUND;
                    fsm_q         <= ROUND;
                end
                ROUND: begin
                    cipherState_q <= roundState_d;
                    roundKey_q    <= keyBwd_d;
                    rcon_q        <= rconPrev_d;
                    roundCnt_q    <= roundCnt_q - 4'd1;
                    if (roundCnt_q == 4'd0) begin
                        plainOut_q <= roundState_d;
                        validOut_q <= 1'b1;
                        busy_q     <= 1'b0;
                        fsm_q      <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign valid_out = validOut_q;
    assign plain_out = plainOut_q;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed bench for aes_decrypt_core using the FIPS-197 C.1 and Appendix B vectors.
// Build with AES_DEC_KEYCACHE_EN defined to expect 11-cycle latency on repeated keys.
module tb_aes_decrypt_core;

    localparam logic [127:0] C1_KEY    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CIPHER = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PLAIN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CIPHER  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PLAIN   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam int FULL_LAT = 21;
`ifdef AES_DEC_KEYCACHE_EN
    localparam int HIT_LAT = 11;
`else
    localparam int HIT_LAT = 21;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] cipher_in;
    logic [127:0] key_in;
    logic         busy;
    logic         valid_out;
    logic [127:0] plain_out;

    int checks   = 0;
    int failures = 0;

    aes_decrypt_core dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cipher_in (cipher_in),
        .key_in    (key_in),
        .busy      (busy),
        .valid_out (valid_out),
        .plain_out (plain_out)
    );

    always #5 clk = ~clk;

    // Called 1 time unit after a rising edge with the core idle; returns the number of edges
    // after the accepting edge until valid_out is seen, or -1 if it never appears.
    task automatic doBlock(input logic [127:0] k, input logic [127:0] c, output int lat);
        key_in    = k;
        cipher_in = c;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (valid_out === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        key_in    = '0;
        cipher_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_out); end
        checks++;
        if (plain_out !== 128'h0) begin failures++; $display("[TB] FAIL reset_plain: got %h expected 0", plain_out); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_c1();
        int lat;
        doBlock(C1_KEY, C1_CIPHER, lat);
        checks++;
        if (lat != FULL_LAT) begin failures++; $display("[TB] FAIL c1_latency: got %0d expected %0d", lat, FULL_LAT); end
        checks++;
        if (plain_out !== C1_PLAIN) begin failures++; $display("[TB] FAIL c1_plain: got %h expected %h", plain_out, C1_PLAIN); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL c1_busy_at_valid: got %b expected 0", busy); end
        @(posedge clk); #1;
        checks++;
        if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL c1_valid_pulse: got %b expected 0", valid_out); end
        checks++;
        if (plain_out !== C1_PLAIN) begin failures++; $display("[TB] FAIL c1_plain_held: got %h expected %h", plain_out, C1_PLAIN); end
    endtask

    task automatic test_fips_b();
        int lat;
        doBlock(B_KEY, B_CIPHER, lat);
        checks++;
        if (lat != FULL_LAT) begin failures++; $display("[TB] FAIL b_latency: got %0d expected %0d", lat, FULL_LAT); end
        checks++;
        if (plain_out !== B_PLAIN) begin failures++; $display("[TB] FAIL b_plain: got %h expected %h", plain_out, B_PLAIN); end
        @(posedge clk); #1;
    endtask

    // The aborted C.1 block caches its key before the reset; the cache must not survive it.
    task automatic test_reset_midblock();
        int lat;
        int pulses;
        int busyHigh;
        key_in    = C1_KEY;
        cipher_in = C1_CIPHER;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        checks++;
        if (plain_out !== 128'h0) begin failures++; $display("[TB] FAIL midreset_plain: got %h expected 0", plain_out); end
        checks++;
        if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL midreset_valid: got %b expected 0", valid_out); end
        @(posedge clk); #1;
        rst      = 1'b0;
        pulses   = 0;
        busyHigh = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (valid_out === 1'b1) pulses++;
            if (busy !== 1'b0) busyHigh++;
        end
        checks++;
        if (pulses != 0) begin failures++; $display("[TB] FAIL midreset_no_valid: got %0d pulses expected 0", pulses); end
        checks++;
        if (busyHigh != 0) begin failures++; $display("[TB] FAIL midreset_no_resume: got %0d busy cycles expected 0", busyHigh); end
        doBlock(C1_KEY, C1_CIPHER, lat);
        checks++;
        if (lat != FULL_LAT) begin failures++; $display("[TB] FAIL postreset_latency: got %0d expected %0d", lat, FULL_LAT); end
        checks++;
        if (plain_out !== C1_PLAIN) begin failures++; $display("[TB] FAIL postreset_plain: got %h expected %h", plain_out, C1_PLAIN); end
        @(posedge clk); #1;
    endtask

    // The C.1 key was the last one used, so the first block is a cache hit when caching is built in.
    task automatic test_back_to_back();
        int lat1;
        int lat2;
        doBlock(C1_KEY, C1_CIPHER, lat1);
        checks++;
        if (lat1 != HIT_LAT) begin failures++; $display("[TB] FAIL b2b_first_latency: got %0d expected %0d", lat1, HIT_LAT); end
        checks++;
        if (plain_out !== C1_PLAIN) begin failures++; $display("[TB] FAIL b2b_first_plain: got %h expected %h", plain_out, C1_PLAIN); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle_in_valid: got %b expected 0", busy); end
        doBlock(B_KEY, B_CIPHER, lat2);
        checks++;
        if (lat2 != FULL_LAT) begin failures++; $display("[TB] FAIL b2b_second_latency: got %0d expected %0d", lat2, FULL_LAT); end
        checks++;
        if (plain_out !== B_PLAIN) begin failures++; $display("[TB] FAIL b2b_second_plain: got %h expected %h", plain_out, B_PLAIN); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_while_busy();
        int lat;
        int pulses;
        logic [127:0] seenPlain;
        lat       = -1;
        pulses    = 0;
        seenPlain = '0;
        key_in    = C1_KEY;
        cipher_in = C1_CIPHER;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk); #1;
            if (i == 5) begin
                checks++;
                if (busy !== 1'b1) begin failures++; $display("[TB] FAIL busy_during_block: got %b expected 1", busy); end
                key_in    = B_KEY;
                cipher_in = B_CIPHER;
                start     = 1'b1;
            end
            if (i == 6) begin
                start     = 1'b0;
                key_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
                cipher_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (valid_out === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat       = i;
                    seenPlain = plain_out;
                end
            end
        end
        checks++;
        if (lat != FULL_LAT) begin failures++; $display("[TB] FAIL ignore_latency: got %0d expected %0d", lat, FULL_LAT); end
        checks++;
        if (seenPlain !== C1_PLAIN) begin failures++; $display("[TB] FAIL ignore_plain: got %h expected %h", seenPlain, C1_PLAIN); end
        checks++;
        if (pulses != 1) begin failures++; $display("[TB] FAIL ignore_single_valid: got %0d pulses expected 1", pulses); end
    endtask

    task automatic test_keycache();
        int lat;
        doBlock(C1_KEY, C1_CIPHER, lat);
        checks++;
        if (lat != HIT_LAT) begin failures++; $display("[TB] FAIL cache_repeat_latency: got %0d expected %0d", lat, HIT_LAT); end
        checks++;
        if (plain_out !== C1_PLAIN) begin failures++; $display("[TB] FAIL cache_repeat_plain: got %h expected %h", plain_out, C1_PLAIN); end
        @(posedge clk); #1;
        doBlock(B_KEY, B_CIPHER, lat);
        checks++;
        if (lat != FULL_LAT) begin failures++; $display("[TB] FAIL cache_miss_latency: got %0d expected %0d", lat, FULL_LAT); end
        checks++;
        if (plain_out !== B_PLAIN) begin failures++; $display("[TB] FAIL cache_miss_plain: got %h expected %h", plain_out, B_PLAIN); end
        @(posedge clk); #1;
        doBlock(B_KEY, B_CIPHER, lat);
        checks++;
        if (lat != HIT_LAT) begin failures++; $display("[TB] FAIL cache_b_repeat_latency: got %0d expected %0d", lat, HIT_LAT); end
        checks++;
        if (plain_out !== B_PLAIN) begin failures++; $display("[TB] FAIL cache_b_repeat_plain: got %h expected %h", plain_out, B_PLAIN); end
        @(posedge clk); #1;
    endtask

    initial begin
        $display("[TB] aes_decrypt_core directed tests starting");
        test_reset();
        test_c1();
        test_fips_b();
        test_reset_midblock();
        test_back_to_back();
        test_start_while_busy();
        test_keycache();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
